uart_tx_scheduler: RTL and testbench

- Shares one UART device transmit path between four requesters using round-robin arbitration.
- Accepts one 9-bit frame per valid/ready handshake and drives the device's start strobe and data input.
- Holds off further grants until the device reports frame completion.
- Sits between the system-side producers and a UART device's `Start_Signal_In`/`Data_In` pair, on the same system clock as the baud rate generator.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_scheduler_if.sv | 25 ++
 rtl/uart_rr_arbiter.sv | 32 +++
 rtl/uart_tx_scheduler.sv | 114 +++++++++++
 tb/tb_uart_tx_scheduler.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants and state type for the UART transmit scheduler.
package uart_pkg;

  localparam int UART_NUM_REQ = 4;
  localparam int UART_DATA_W  = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2
  } uart_state_e;

endpackage

// File: rtl/uart_tx_scheduler_if.sv
// Requester handshake and UART device signals of the transmit scheduler.
interface uart_tx_scheduler_if;
  import uart_pkg::*;

  logic [UART_NUM_REQ-1:0]             Req_Valid_In;
  logic [UART_NUM_REQ*UART_DATA_W-1:0] Req_Data_In;
  logic [UART_NUM_REQ-1:0]             Req_Ready_Out;
  logic                                Start_Signal_Out;
  logic [UART_DATA_W-1:0]              Data_Out;
  logic                                Tx_Done_In;
  logic [1:0]                          Grant_Id_Out;
  logic                                Busy_Out;
  logic                                Timeout_Out;

  modport master (
    output Req_Valid_In, Req_Data_In, Tx_Done_In,
    input  Req_Ready_Out, Start_Signal_Out, Data_Out, Grant_Id_Out, Busy_Out, Timeout_Out
  );

  modport slave (
    input  Req_Valid_In, Req_Data_In, Tx_Done_In,
    output Req_Ready_Out, Start_Signal_Out, Data_Out, Grant_Id_Out, Busy_Out, Timeout_Out
  );

endinterface

// File: rtl/uart_rr_arbiter.sv
// Combinational round-robin arbiter: scans upward from ptr+1 (mod 4) for the
// first active request and returns a one-hot grant plus its index.
module uart_rr_arbiter
  import uart_pkg::*;
(
  input  logic [UART_NUM_REQ-1:0] req,
  input  logic [1:0]              ptr,
  output logic [UART_NUM_REQ-1:0] grant,
  output logic [1:0]              grant_idx,
  output logic                    found
);

  logic [1:0] cand;
  logic       hit;

  // Each candidate is visited exactly once, so grant[cand] is written once per scan.
  always_comb begin
    grant     = '0;
    grant_idx = 2'd0;
    found     = 1'b0;
    cand      = ptr;
    hit       = 1'b0;
    for (int k = 1; k <= UART_NUM_REQ; k++) begin
      cand        = ptr + 2'(k);
      hit         = ~found & req[cand];
      grant[cand] = hit;
      grant_idx   = hit ? cand : grant_idx;
      found       = found | hit;
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmit path among four requesters.
// Defining UART_TX_SCHED_TIMEOUT_EN adds a watchdog on the wait-for-done phase.
module uart_tx_scheduler
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = UART_NUM_REQ,
  parameter int DATA_W         = UART_DATA_W,
  parameter int TIMEOUT_CYCLES = 2_000_000
) (
  input logic                Clk_In,
  input logic                Reset_In,
  uart_tx_scheduler_if.slave bus
);

  uart_state_e        state;
  uart_state_e        state_next;
  logic [1:0]         ptr;
  logic [NUM_REQ-1:0] grant;
  logic [1:0]         grant_idx;
  logic               found;
  logic [DATA_W-1:0]  data_q;
  logic [1:0]         gid_q;
  logic               start_q;
  logic               busy_q;
  logic               timeout_q;
  logic               expire;

  uart_rr_arbiter u_arb (
    .req       (bus.Req_Valid_In),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .found     (found)
  );

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wd_cnt;

  // Watchdog counts cycles spent in WAIT_DONE; cleared while START is on its way in.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      wd_cnt <= '0;
    end else if (state == START) begin
      wd_cnt <= '0;
    end else if (state == WAIT_DONE) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end else begin
      wd_cnt <= wd_cnt;
    end
  end

  // A done pulse in the expiry cycle wins over the timeout.
  assign expire = (state == WAIT_DONE) && (wd_cnt == CNT_LAST) && !bus.Tx_Done_In;
`else
  assign expire = 1'b0;
`endif

  // State register.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; done is only honoured in WAIT_DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = found ? START : IDLE;
      START:     state_next = WAIT_DONE;
      WAIT_DONE: state_next = (bus.Tx_Done_In || expire) ? IDLE : WAIT_DONE;
      default:   state_next = IDLE;
    endcase
  end

  // Frame latch, pointer and registered status outputs.
  always_ff @(posedge Clk_In or posedge Reset_In) begin
    if (Reset_In) begin
      ptr       <= 2'd3;
      data_q    <= '0;
      gid_q     <= 2'd0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (state == IDLE && found) begin
        ptr    <= grant_idx;
        gid_q  <= grant_idx;
        data_q <= bus.Req_Data_In[int'(grant_idx)*DATA_W +: DATA_W];
      end else begin
        ptr    <= ptr;
        gid_q  <= gid_q;
        data_q <= data_q;
      end
      start_q   <= (state_next == START);
      busy_q    <= (state_next != IDLE);
      timeout_q <= expire;
    end
  end

  // Ready is combinational so a requester is accepted in the cycle it is selected.
  assign bus.Req_Ready_Out    = (state == IDLE && !Reset_In) ? grant : '0;
  assign bus.Start_Signal_Out = start_q;
  assign bus.Data_Out         = data_q;
  assign bus.Grant_Id_Out     = gid_q;
  assign bus.Busy_Out         = busy_q;
  assign bus.Timeout_Out      = timeout_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and directed bench for uart_tx_scheduler against a transaction-level model.
module tb_uart_tx_scheduler;
  import uart_pkg::*;

  localparam int TB_TIMEOUT = 16;

  logic Clk_In = 1'b0;
  logic Reset_In;

  uart_tx_scheduler_if bus ();

  uart_tx_scheduler #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .Clk_In   (Clk_In),
    .Reset_In (Reset_In),
    .bus      (bus)
  );

  always #5 Clk_In = ~Clk_In;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: one transaction in flight at most.
  int         cyc;
  int         last;
  bit         active;
  int         start_cyc;
  int         to_cyc;
  int         to_pulses;
  logic [1:0] exp_id;
  logic [8:0] exp_data;
  logic [3:0] exp_ready;
  logic [3:0] acc;
  bit         pend [4];
  logic [8:0] fr   [4];
  int         grants_q [$];
  int         req_mode;
  int         done_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int qget(input int i);
    if (i < grants_q.size()) return grants_q[i];
    return -1;
  endfunction

  task automatic drive_inputs();
    logic d;
    for (int i = 0; i < 4; i++) begin
      if (acc[i]) pend[i] = 1'b0;
      if (!pend[i] && (req_mode == 1 || (req_mode == 0 && $urandom_range(0, 9) < 3))) begin
        pend[i] = 1'b1;
        fr[i]   = 9'($urandom);
      end else if (pend[i] && req_mode == 0 && $urandom_range(0, 19) == 0) begin
        pend[i] = 1'b0;
      end
      bus.Req_Valid_In[i]         = pend[i];
      bus.Req_Data_In[i*9 +: 9]   = fr[i];
    end
    acc = 4'd0;
    case (done_mode)
      0:       d = (active && cyc > start_cyc) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 7) == 0);
      1:       d = active && (cyc == start_cyc + 5);
      2:       d = active && (cyc == start_cyc || cyc == start_cyc + 4);
      3:       d = 1'b0;
      default: d = active && (cyc == start_cyc + TB_TIMEOUT);
    endcase
    bus.Tx_Done_In = d;
  endtask

  task automatic check_outputs();
    exp_ready = 4'd0;
    if (!active) begin
      for (int k = 1; k <= 4; k++) begin
        if (bus.Req_Valid_In[(last + k) % 4]) begin
          exp_ready[(last + k) % 4] = 1'b1;
          break;
        end
      end
    end
    check("ready",   bus.Req_Ready_Out,    exp_ready);
    check("start",   bus.Start_Signal_Out, active && (cyc == start_cyc));
    check("busy",    bus.Busy_Out,         active);
    check("data",    bus.Data_Out,         exp_data);
    check("gid",     bus.Grant_Id_Out,     exp_id);
    check("timeout", bus.Timeout_Out,      cyc == to_cyc);
    if (bus.Timeout_Out) to_pulses++;
  endtask

  task automatic model_edge();
    if (!active) begin
      for (int i = 0; i < 4; i++) begin
        if (exp_ready[i]) begin
          active    = 1'b1;
          start_cyc = cyc + 1;
          last      = i;
          exp_id    = 2'(i);
          exp_data  = fr[i];
          acc[i]    = 1'b1;
          grants_q.push_back(i);
        end
      end
    end else if (cyc > start_cyc) begin
      if (bus.Tx_Done_In) begin
        active = 1'b0;
      end
`ifdef UART_TX_SCHED_TIMEOUT_EN
      else if (cyc == start_cyc + TB_TIMEOUT) begin
        active = 1'b0;
        to_cyc = cyc + 1;
      end
`endif
    end
  endtask

  task automatic run_cycle();
    drive_inputs();
    @(negedge Clk_In);
    check_outputs();
    @(posedge Clk_In);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    Reset_In = 1'b1;
    for (int i = 0; i < 4; i++) pend[i] = 1'b0;
    acc              = 4'd0;
    bus.Req_Valid_In = 4'd0;
    bus.Tx_Done_In   = 1'b0;
    @(negedge Clk_In);
    check("rst_busy",  bus.Busy_Out,         1'b0);
    check("rst_start", bus.Start_Signal_Out, 1'b0);
    check("rst_data",  bus.Data_Out,         9'h000);
    check("rst_gid",   bus.Grant_Id_Out,     2'd0);
    check("rst_to",    bus.Timeout_Out,      1'b0);
    @(posedge Clk_In);
    #1;
    Reset_In  = 1'b0;
    last      = 3;
    active    = 1'b0;
    exp_id    = 2'd0;
    exp_data  = 9'h000;
    to_cyc    = -100;
    to_pulses = 0;
    grants_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    Reset_In         = 1'b1;
    bus.Req_Valid_In = 4'd0;
    bus.Req_Data_In  = '0;
    bus.Tx_Done_In   = 1'b0;
    cyc = 0; acc = 4'd0; req_mode = 2; done_mode = 3;
    for (int i = 0; i < 4; i++) fr[i] = 9'h000;
    @(posedge Clk_In);
    #1;

    // Requesters 0 and 2 valid after reset: 0 first, then 2.
    apply_reset();
    pend[0] = 1'b1; fr[0] = 9'h033;
    pend[2] = 1'b1; fr[2] = 9'h155;
    req_mode = 2; done_mode = 1;
    repeat (20) run_cycle();
    check("t1_n",  grants_q.size(), 2);
    check("t1_g0", qget(0), 0);
    check("t1_g1", qget(1), 2);

    // All four continuously valid: strict rotation.
    apply_reset();
    req_mode = 1; done_mode = 1;
    repeat (40) run_cycle();
    for (int i = 0; i < 5; i++) check("t2_order", qget(i), i % 4);

    // Fixed frame, done pulse during START must be ignored.
    apply_reset();
    pend[1] = 1'b1; fr[1] = 9'h1A5;
    req_mode = 2; done_mode = 2;
    repeat (3) run_cycle();
    check("t3_data_wait", bus.Data_Out, 9'h1A5);
    check("t3_busy_wait", bus.Busy_Out, 1'b1);
    repeat (5) run_cycle();
    check("t3_data_hold", bus.Data_Out, 9'h1A5);
    check("t3_gid",       bus.Grant_Id_Out, 2'd1);

    // Asynchronous reset in WAIT_DONE, then grant restarts at requester 0.
    apply_reset();
    pend[2] = 1'b1; fr[2] = 9'h0F0;
    req_mode = 2; done_mode = 3;
    repeat (4) run_cycle();
    check("t4_pre_busy", bus.Busy_Out, 1'b1);
    bus.Req_Valid_In = 4'hF;
    #1 Reset_In = 1'b1;
    #1;
    check("t4_async_busy",  bus.Busy_Out,         1'b0);
    check("t4_async_data",  bus.Data_Out,         9'h000);
    check("t4_async_gid",   bus.Grant_Id_Out,     2'd0);
    check("t4_async_ready", bus.Req_Ready_Out,    4'd0);
    check("t4_async_start", bus.Start_Signal_Out, 1'b0);
    apply_reset();
    req_mode = 1; done_mode = 1;
    repeat (3) run_cycle();
    check("t4_first", qget(0), 0);

    // No done: busy forever, or a timeout when the watchdog is built in.
    apply_reset();
    pend[3] = 1'b1; fr[3] = 9'h0AA;
    req_mode = 2; done_mode = 3;
    repeat (40) run_cycle();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    check("t5_to_pulses", to_pulses, 1);
    check("t5_busy",      bus.Busy_Out, 1'b0);
    // Done in the expiry cycle suppresses the timeout.
    apply_reset();
    pend[0] = 1'b1; fr[0] = 9'h111;
    req_mode = 2; done_mode = 4;
    repeat (30) run_cycle();
    check("t6_to_pulses", to_pulses, 0);
    check("t6_busy",      bus.Busy_Out, 1'b0);
`else
    check("t5_busy",      bus.Busy_Out, 1'b1);
    check("t5_to_pulses", to_pulses, 0);
`endif

    // Randomized traffic.
    apply_reset();
    req_mode = 0; done_mode = 0;
    repeat (2000) run_cycle();
    check("rand_progress", (grants_q.size() > 50) ? 1 : 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
